// File: rtl/video_timing_pkg.sv
// Shared timing constants and types for the raster timing generator.
// Defaults describe 720x480p60 on a 27 MHz pixel clock.
package video_timing_pkg;

    localparam int COORD_W = 11;

    localparam int DEF_H_ACTIVE = 720;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 62;
    localparam int DEF_H_BP     = 60;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 30;
    localparam bit DEF_SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    // One pixel-clock worth of timing, for stages that pipeline it further.
    typedef struct packed {
        logic   hsync;
        logic   vsync;
        logic   de;
        coord_t x;
        coord_t y;
    } video_timing_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle from the generator to the renderer and TMDS encoder.
// No handshake: sinks take one pixel per clock while de is high.
interface video_timing_if;

    logic                    hsync;
    logic                    vsync;
    logic                    de;
    video_timing_pkg::coord_t x;
    video_timing_pkg::coord_t y;
    logic                    line_start;
    logic                    frame_start;

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start
    );

endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with a registered decode stage,
// so all outputs lag the counter state they describe by exactly one clock.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    video_timing_if.master vid
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_h_total_bad
        $error("video_timing_gen: H_TOTAL out of range for 11-bit counter");
    end
    if (V_TOTAL > 2048 || V_TOTAL < 1) begin : g_v_total_bad
        $error("video_timing_gen: V_TOTAL out of range for 11-bit counter");
    end

    // Limits are one bit wider than the counters so a region ending at 2048 still compares correctly.
    localparam int LIM_W = COORD_W + 1;
    typedef logic [LIM_W-1:0] lim_t;

    localparam lim_t ACT_LIM [2] = '{lim_t'(H_ACTIVE), lim_t'(V_ACTIVE)};
    localparam lim_t SYNC_LO [2] = '{lim_t'(H_ACTIVE + H_FP), lim_t'(V_ACTIVE + V_FP)};
    localparam lim_t SYNC_HI [2] = '{lim_t'(H_ACTIVE + H_FP + H_SYNC),
                                     lim_t'(V_ACTIVE + V_FP + V_SYNC)};

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam logic   SYNC_IDLE = ~SYNC_POL;

    localparam video_timing_t PIX_IDLE = '{
        hsync: SYNC_IDLE,
        vsync: SYNC_IDLE,
        de:    1'b0,
        x:     '0,
        y:     '0
    };

    coord_t        h_cnt_reg;
    coord_t        v_cnt_reg;
    logic          h_wrap;
    logic          v_wrap;
    coord_t        axis_cnt [2];
    logic [1:0]    in_active;
    logic [1:0]    in_sync;

    video_timing_t pix_next;
    video_timing_t pix_reg;
    logic          line_start_next;
    logic          line_start_reg;
    logic          frame_start_next;
    logic          frame_start_reg;

    assign h_wrap = (h_cnt_reg == H_LAST);
    assign v_wrap = (v_cnt_reg == V_LAST);

    // The vertical counter only advances on a horizontal wrap, so both wrap together at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (en) begin
            if (h_wrap) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + coord_t'(1);
            end else begin
                h_cnt_reg <= h_cnt_reg + coord_t'(1);
            end
        end
    end

    assign axis_cnt[0] = h_cnt_reg;
    assign axis_cnt[1] = v_cnt_reg;

    // Index 0 is the horizontal axis, index 1 the vertical; both use the same region layout.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_axis
        assign in_active[gi] = ({1'b0, axis_cnt[gi]} < ACT_LIM[gi]);
        assign in_sync[gi]   = ({1'b0, axis_cnt[gi]} >= SYNC_LO[gi]) &&
                               ({1'b0, axis_cnt[gi]} <  SYNC_HI[gi]);
    end

    always_comb begin
        pix_next       = PIX_IDLE;
        pix_next.de    = &in_active;
        pix_next.hsync = in_sync[0] ? SYNC_POL : SYNC_IDLE;
        pix_next.vsync = in_sync[1] ? SYNC_POL : SYNC_IDLE;
        // Coordinates are forced to zero in blanking so sinks never see porch/sync positions.
        if (pix_next.de) begin
            pix_next.x = h_cnt_reg;
            pix_next.y = v_cnt_reg;
        end
        line_start_next  = (h_cnt_reg == '0);
        frame_start_next = line_start_next && (v_cnt_reg == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pix_reg         <= PIX_IDLE;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pix_reg         <= pix_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign vid.hsync       = pix_reg.hsync;
    assign vid.vsync       = pix_reg.vsync;
    assign vid.de          = pix_reg.de;
    assign vid.x           = pix_reg.x;
    assign vid.y           = pix_reg.y;
    assign vid.line_start  = line_start_reg;
    assign vid.frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three parameter sets run side by side against a
// position-based reference model, plus line/frame period and region checks.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    typedef struct packed {
        int   ha; int hf; int hs; int hb;
        int   va; int vf; int vs; int vb;
        logic pol;
    } tim_t;

    localparam tim_t TA = '{ha: DEF_H_ACTIVE, hf: DEF_H_FP, hs: DEF_H_SYNC, hb: DEF_H_BP,
                            va: DEF_V_ACTIVE, vf: DEF_V_FP, vs: DEF_V_SYNC, vb: DEF_V_BP,
                            pol: DEF_SYNC_POL};
    localparam tim_t TV = '{ha: 640, hf: 16, hs: 96, hb: 48,
                            va: 480, vf: 10, vs: 2,  vb: 33, pol: 1'b1};
    localparam tim_t TC = '{ha: 8, hf: 2, hs: 3, hb: 3,
                            va: 5, vf: 1, vs: 2, vb: 2, pol: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    video_timing_if vid_a ();
    video_timing_if vid_b ();
    video_timing_if vid_c ();

    video_timing_gen dut_a (.clk(clk), .rst(rst), .en(en), .vid(vid_a));

    video_timing_gen #(
        .H_ACTIVE(TV.ha), .H_FP(TV.hf), .H_SYNC(TV.hs), .H_BP(TV.hb),
        .V_ACTIVE(TV.va), .V_FP(TV.vf), .V_SYNC(TV.vs), .V_BP(TV.vb), .SYNC_POL(1'b1)
    ) dut_b (.clk(clk), .rst(rst), .en(en), .vid(vid_b));

    video_timing_gen #(
        .H_ACTIVE(TC.ha), .H_FP(TC.hf), .H_SYNC(TC.hs), .H_BP(TC.hb),
        .V_ACTIVE(TC.va), .V_FP(TC.vf), .V_SYNC(TC.vs), .V_BP(TC.vb), .SYNC_POL(1'b0)
    ) dut_c (.clk(clk), .rst(rst), .en(en), .vid(vid_c));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int line_len(input tim_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int frame_len(input tim_t t);
        return line_len(t) * (t.va + t.vf + t.vs + t.vb);
    endfunction

    // Expected outputs for linear frame position pos, packed as {5'b0, hs, vs, de, x, y, ls, fs}.
    function automatic logic [31:0] ref_out(input tim_t t, input int pos);
        int h, v;
        logic de, hs, vs;
        logic [10:0] xo, yo;
        h  = pos % line_len(t);
        v  = pos / line_len(t);
        de = (h < t.ha) && (v < t.va);
        hs = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.pol : ~t.pol;
        vs = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.pol : ~t.pol;
        xo = de ? 11'(h) : 11'd0;
        yo = de ? 11'(v) : 11'd0;
        return {5'b0, hs, vs, de, xo, yo, (h == 0), (pos == 0)};
    endfunction

    function automatic logic [31:0] idle_out(input logic pol);
        return {5'b0, ~pol, ~pol, 25'b0};
    endfunction

    logic [31:0] obs_a, obs_b, obs_c;
    assign obs_a = {5'b0, vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.x, vid_a.y,
                    vid_a.line_start, vid_a.frame_start};
    assign obs_b = {5'b0, vid_b.hsync, vid_b.vsync, vid_b.de, vid_b.x, vid_b.y,
                    vid_b.line_start, vid_b.frame_start};
    assign obs_c = {5'b0, vid_c.hsync, vid_c.vsync, vid_c.de, vid_c.x, vid_c.y,
                    vid_c.line_start, vid_c.frame_start};

    // Reference model: tracks a linear position per instance and samples rst/en at each edge.
    int          cyc = 0;
    bit          started = 1'b0;
    int          pos_a = 0, pos_b = 0, pos_c = 0;
    logic [31:0] exp_a, exp_b, exp_c;
    logic        seen_rst = 1'b1;
    logic        seen_en  = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        started  <= 1'b1;
        seen_rst <= rst;
        seen_en  <= en;
        if (rst) begin
            pos_a <= 0; pos_b <= 0; pos_c <= 0;
            exp_a <= idle_out(TA.pol);
            exp_b <= idle_out(TV.pol);
            exp_c <= idle_out(TC.pol);
        end else if (en) begin
            exp_a <= ref_out(TA, pos_a);
            exp_b <= ref_out(TV, pos_b);
            exp_c <= ref_out(TC, pos_c);
            pos_a <= (pos_a + 1) % frame_len(TA);
            pos_b <= (pos_b + 1) % frame_len(TV);
            pos_c <= (pos_c + 1) % frame_len(TC);
        end else begin
            exp_a <= idle_out(TA.pol);
            exp_b <= idle_out(TV.pol);
            exp_c <= idle_out(TC.pol);
        end
    end

    // Period and region trackers; every en-low edge delays the next event by one clock.
    int a_ls_last, a_gap = 0;       bit a_ls_ok = 0;
    int b_ls_last, b_gap = 0;       bit b_ls_ok = 0;
    int c_fs_last, c_gap = 0;       bit c_fs_ok = 0;
    bit a_line_ok = 0;  int a_de_cnt, a_hs_cnt, a_de_last, a_hs_first;
    int a_lines_checked = 0;
    bit b_line_ok = 0;  int b_hs_cnt;
    bit c_frame_ok = 0; int c_de_lines, c_vs_cnt; logic c_vs_prev = 1'b1;
    int c_frames_checked = 0;

    always @(negedge clk) begin
        if (started) begin
            check_val("a_pix", obs_a, exp_a);
            check_val("b_pix", obs_b, exp_b);
            check_val("c_pix", obs_c, exp_c);

            if (seen_rst) begin
                a_ls_ok = 0; b_ls_ok = 0; c_fs_ok = 0;
            end else if (!seen_en) begin
                a_gap++; b_gap++; c_gap++;
            end
            if (seen_rst || !seen_en) begin
                a_line_ok = 0; b_line_ok = 0; c_frame_ok = 0;
            end

            if (vid_a.line_start) begin
                if (a_ls_ok) check_val("a_line_period", cyc - a_ls_last, line_len(TA) + a_gap);
                a_ls_last = cyc; a_ls_ok = 1; a_gap = 0;
                if (a_line_ok) begin
                    a_lines_checked++;
                    check_val("a_hsync_width", a_hs_cnt, TA.hs);
                    if (a_de_cnt > 0) begin
                        check_val("a_de_count", a_de_cnt, TA.ha);
                        check_val("a_hs_after_de", a_hs_first - a_de_last - 1, TA.hf);
                    end
                end
                a_line_ok = 1; a_de_cnt = 0; a_hs_cnt = 0;
            end
            if (vid_a.de) begin
                a_de_cnt++; a_de_last = cyc;
            end
            if (vid_a.hsync == TA.pol) begin
                if (a_hs_cnt == 0) a_hs_first = cyc;
                a_hs_cnt++;
            end

            if (vid_b.line_start) begin
                if (b_ls_ok) check_val("b_line_period", cyc - b_ls_last, line_len(TV) + b_gap);
                b_ls_last = cyc; b_ls_ok = 1; b_gap = 0;
                if (b_line_ok) check_val("b_hsync_high_width", b_hs_cnt, TV.hs);
                b_line_ok = 1; b_hs_cnt = 0;
            end
            if (vid_b.hsync) b_hs_cnt++;

            if (c_frame_ok && vid_c.vsync != c_vs_prev)
                check_val("c_vs_edge_on_ls", {31'b0, vid_c.line_start}, 32'd1);
            if (vid_c.frame_start) begin
                if (c_fs_ok) check_val("c_frame_period", cyc - c_fs_last, frame_len(TC) + c_gap);
                c_fs_last = cyc; c_fs_ok = 1; c_gap = 0;
                if (c_frame_ok) begin
                    c_frames_checked++;
                    check_val("c_de_lines", c_de_lines, TC.va);
                    check_val("c_vsync_clocks", c_vs_cnt, TC.vs * line_len(TC));
                end
                c_frame_ok = 1; c_de_lines = 0; c_vs_cnt = 0;
            end
            if (vid_c.de && vid_c.x == 11'd0) c_de_lines++;
            if (vid_c.vsync == TC.pol) c_vs_cnt++;
            c_vs_prev = vid_c.vsync;
        end
    end

    task automatic wait_pos_a(input int target);
        int n;
        n = 0;
        while (pos_a != target && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_pos_a", pos_a, target);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_a_hsync", {31'b0, vid_a.hsync}, 32'd1);
        check_val("rst_a_vsync", {31'b0, vid_a.vsync}, 32'd1);
        check_val("rst_a_de",    {31'b0, vid_a.de}, 32'd0);
        check_val("rst_a_fs",    {31'b0, vid_a.frame_start}, 32'd0);
        check_val("rst_b_hsync", {31'b0, vid_b.hsync}, 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        check_val("start_a_fs", {31'b0, vid_a.frame_start}, 32'd1);
        check_val("start_a_ls", {31'b0, vid_a.line_start}, 32'd1);
        check_val("start_a_de", {31'b0, vid_a.de}, 32'd1);
        check_val("start_a_xy", {10'b0, vid_a.x, vid_a.y}, 32'd0);

        // Enable gap of 100 clocks with the counters at h=300, v=10.
        wait_pos_a(10 * line_len(TA) + 300);
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 50) begin
                check_val("gap_a_de",    {31'b0, vid_a.de}, 32'd0);
                check_val("gap_a_hsync", {31'b0, vid_a.hsync}, 32'd1);
                check_val("gap_a_x",     {21'b0, vid_a.x}, 32'd0);
            end
        end
        en = 1'b1;
        @(negedge clk);
        check_val("resume_a_x", {21'b0, vid_a.x}, 32'd300);
        check_val("resume_a_y", {21'b0, vid_a.y}, 32'd10);

        // One-clock reset mid-frame at h=500, v=20 with en held high.
        wait_pos_a(20 * line_len(TA) + 500);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_a_de",    {31'b0, vid_a.de}, 32'd0);
        check_val("midrst_a_hsync", {31'b0, vid_a.hsync}, 32'd1);
        check_val("midrst_a_vsync", {31'b0, vid_a.vsync}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_val("postrst_a_fs", {31'b0, vid_a.frame_start}, 32'd1);
        check_val("postrst_a_xy", {10'b0, vid_a.x, vid_a.y}, 32'd0);

        // Random enable drops and occasional reset pulses, all followed by the model.
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(300, 60)) @(negedge clk);
            if ($urandom_range(9, 0) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                en = 1'b0;
                repeat ($urandom_range(20, 1)) @(negedge clk);
                en = 1'b1;
            end
        end
        repeat (2500) @(negedge clk);

        check_val("a_lines_checked", {31'b0, (a_lines_checked > 0)}, 32'd1);
        check_val("c_frames_checked", {31'b0, (c_frames_checked > 0)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
